// File: rtl/stopwatch_display_driver.sv
// Four-digit common-anode 7-segment scan driver for the stopwatch time word.
// Snapshots a whole frame at scan wrap, blanks a leading zero, blinks on ALARM.
module stopwatch_display_driver #(
  parameter int SCAN_DIV  = 12500,
  parameter int BLINK_DIV = 250,
  parameter bit BLANK_LZ  = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic        RUNNING,
  input  logic        ALARM,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic [1:0]    idx;
  logic          gap;
  logic [15:0]   frame;

  logic          tick;
  logic [3:0]    digit;
  logic          dark;
  logic [3:0]    an_nx;
  logic [6:0]    seg_nx;
  logic          dp_nx;

  function automatic logic [6:0] dec_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Scan timing: one dark gap cycle opens every digit slot
  always_comb begin
    tick = (prescaler == PRE_LAST);
    digit = 4'd0;
    case (idx)
      2'd0: digit = frame[3:0];
      2'd1: digit = frame[7:4];
      2'd2: digit = frame[11:8];
      2'd3: digit = frame[15:12];
      default: digit = 4'd0;
    endcase
    dark = gap | (ALARM & blink_ph)
         | (BLANK_LZ & (idx == 2'd3) & (frame[15:12] == 4'd0));
    an_nx  = dark ? 4'b1111 : ~(4'b0001 << idx);
    seg_nx = dark ? 7'h7F : dec_seg(digit);
    // Dot sits after minutes units: steady when stopped, blinking while running
    dp_nx  = ~(~dark & (idx == 2'd2) & (RUNNING ? blink_ph : 1'b1));
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      idx       <= 2'd0;
      gap       <= 1'b1;
      frame     <= 16'h0000;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      gap       <= tick;
      if (tick) begin
        idx <= idx + 2'd1;
        // Whole-frame snapshot on wrap keeps digits from tearing mid-scan
        if (idx == 2'd3)
          frame <= bcd_in;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      an_n  <= 4'b1111;
      seg_n <= 7'h7F;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= an_nx;
      seg_n <= seg_nx;
      dp_n  <= dp_nx;
    end
  end

endmodule
